// File: rtl/itcm_arbiter_if.sv
// ITCM arbiter bus bundle: IFU command/response, LSU command/response and
// the single-port RAM side. The arbiter uses the slave view; whoever drives
// the IFU/LSU requests and models the RAM uses the master view.
interface itcm_arbiter_if #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RAM_DEPTH = 14
);
  // IFU side
  logic                 ifu_cmd_valid;
  logic                 ifu_cmd_ready;
  logic [AW-1:0]        ifu_cmd_addr;
  logic                 ifu_rsp_valid;
  logic                 ifu_rsp_ready;
  logic [DW-1:0]        ifu_rsp_rdata;
  logic                 ifu_rsp_err;
  logic                 flush;
  // LSU side
  logic                 lsu_cmd_valid;
  logic                 lsu_cmd_ready;
  logic                 lsu_cmd_read;
  logic [AW-1:0]        lsu_cmd_addr;
  logic [DW-1:0]        lsu_cmd_wdata;
  logic [DW/8-1:0]      lsu_cmd_wmask;
  logic                 lsu_rsp_valid;
  logic                 lsu_rsp_ready;
  logic [DW-1:0]        lsu_rsp_rdata;
  logic                 lsu_rsp_err;
  // RAM side
  logic                 ram_ena;
  logic [DW/8-1:0]      ram_wea;
  logic [RAM_DEPTH-1:0] ram_addr;
  logic [DW-1:0]        ram_din;
  logic [DW-1:0]        ram_dout;

  modport slave (
    input  ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready, flush,
    input  lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata,
    input  lsu_cmd_wmask, lsu_rsp_ready, ram_dout,
    output ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    output lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    output ram_ena, ram_wea, ram_addr, ram_din
  );

  modport master (
    output ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready, flush,
    output lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata,
    output lsu_cmd_wmask, lsu_rsp_ready, ram_dout,
    input  ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    input  lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    input  ram_ena, ram_wea, ram_addr, ram_din
  );
endinterface

// File: rtl/itcm_arbiter.sv
// ITCM arbiter: shares one single-port RAM between the instruction fetch
// unit and the load/store unit. One access per cycle overall; each port has
// a one-deep response slot so a stalled response does not lose RAM data.
// LSU wins by default; the IFU is forced through after STARVE_MAX denials.
module itcm_arbiter #(
  parameter int          AW          = 32,
  parameter int          DW          = 32,
  parameter int          RAM_DEPTH   = 14,
  parameter logic [AW-1:0] REGION_BASE = '0,
  parameter int          STARVE_MAX  = 4
) (
  input  logic           clk,
  input  logic           rst,
  itcm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_LIVE,
    SLOT_HELD
  } slot_e;

  localparam int RW = AW - RAM_DEPTH - 2;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [RW-1:0] REGION     = REGION_BASE[RW-1:0];

  slot_e           ifu_slot_q, ifu_slot_d;
  slot_e           lsu_slot_q, lsu_slot_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [DW-1:0]   ifu_hold_rdata_q, ifu_hold_rdata_d;
  logic            ifu_hold_err_q, ifu_hold_err_d;
  logic [DW-1:0]   lsu_hold_rdata_q, lsu_hold_rdata_d;
  logic            lsu_hold_err_q, lsu_hold_err_d;
  // "zero" marks a LIVE response whose data must not come from ram_dout
  // (error or LSU write); "err" is the error flag for that response.
  logic            ifu_live_zero_q, ifu_live_zero_d;
  logic            ifu_live_err_q, ifu_live_err_d;
  logic            lsu_live_zero_q, lsu_live_zero_d;
  logic            lsu_live_err_q, lsu_live_err_d;

  logic [DW-1:0]   ifu_live_rdata, lsu_live_rdata;
  logic            ifu_fire, lsu_fire;
  logic            grant_ifu, starve_full;
  logic            ifu_acc, lsu_acc;
  logic            ifu_err, lsu_err;

  // Response outputs: LIVE passes RAM data through, HELD replays the hold register
  always_comb begin
    ifu_live_rdata    = ifu_live_zero_q ? '0 : bus.ram_dout;
    lsu_live_rdata    = lsu_live_zero_q ? '0 : bus.ram_dout;
    bus.ifu_rsp_valid = (ifu_slot_q != SLOT_EMPTY) && !bus.flush;
    bus.lsu_rsp_valid = (lsu_slot_q != SLOT_EMPTY);
    bus.ifu_rsp_rdata = '0;
    bus.ifu_rsp_err   = 1'b0;
    bus.lsu_rsp_rdata = '0;
    bus.lsu_rsp_err   = 1'b0;
    case (ifu_slot_q)
      SLOT_LIVE: begin
        bus.ifu_rsp_rdata = ifu_live_rdata;
        bus.ifu_rsp_err   = ifu_live_err_q;
      end
      SLOT_HELD: begin
        bus.ifu_rsp_rdata = ifu_hold_rdata_q;
        bus.ifu_rsp_err   = ifu_hold_err_q;
      end
      default: ;
    endcase
    case (lsu_slot_q)
      SLOT_LIVE: begin
        bus.lsu_rsp_rdata = lsu_live_rdata;
        bus.lsu_rsp_err   = lsu_live_err_q;
      end
      SLOT_HELD: begin
        bus.lsu_rsp_rdata = lsu_hold_rdata_q;
        bus.lsu_rsp_err   = lsu_hold_err_q;
      end
      default: ;
    endcase
    ifu_fire = bus.ifu_rsp_valid && bus.ifu_rsp_ready;
    lsu_fire = bus.lsu_rsp_valid && bus.lsu_rsp_ready;
  end

  // Arbitration, command acceptance and RAM drive
  always_comb begin
    starve_full = (starve_q == STARVE_LIM);
    grant_ifu   = !bus.lsu_cmd_valid || starve_full;
    // Readies are masked by rst so every handshake output is low during reset.
    bus.ifu_cmd_ready = !rst && !bus.flush && grant_ifu &&
                        ((ifu_slot_q == SLOT_EMPTY) || ifu_fire);
    bus.lsu_cmd_ready = !rst && !grant_ifu &&
                        ((lsu_slot_q == SLOT_EMPTY) || lsu_fire);
    ifu_acc = bus.ifu_cmd_valid && bus.ifu_cmd_ready;
    lsu_acc = bus.lsu_cmd_valid && bus.lsu_cmd_ready;
    ifu_err = (bus.ifu_cmd_addr[1:0] != 2'b00) ||
              (bus.ifu_cmd_addr[AW-1:RAM_DEPTH+2] != REGION);
    lsu_err = (bus.lsu_cmd_addr[1:0] != 2'b00) ||
              (bus.lsu_cmd_addr[AW-1:RAM_DEPTH+2] != REGION);

    bus.ram_ena  = 1'b0;
    bus.ram_wea  = '0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (ifu_acc && !ifu_err) begin
      bus.ram_ena  = 1'b1;
      bus.ram_addr = bus.ifu_cmd_addr[RAM_DEPTH+1:2];
      bus.ram_din  = bus.lsu_cmd_wdata;
    end else if (lsu_acc && !lsu_err) begin
      bus.ram_ena  = 1'b1;
      bus.ram_addr = bus.lsu_cmd_addr[RAM_DEPTH+1:2];
      bus.ram_din  = bus.lsu_cmd_wdata;
      if (!bus.lsu_cmd_read) bus.ram_wea = bus.lsu_cmd_wmask;
    end
  end

  // Next state: starve counter and per-port response slots
  always_comb begin
    starve_d = starve_q;
    if (!bus.ifu_cmd_valid || ifu_acc) starve_d = '0;
    else if (!starve_full)             starve_d = starve_q + 1'b1;

    ifu_slot_d       = ifu_slot_q;
    ifu_hold_rdata_d = ifu_hold_rdata_q;
    ifu_hold_err_d   = ifu_hold_err_q;
    ifu_live_zero_d  = ifu_live_zero_q;
    ifu_live_err_d   = ifu_live_err_q;
    case (ifu_slot_q)
      SLOT_LIVE: begin
        if (ifu_fire) begin
          ifu_slot_d = SLOT_EMPTY;
        end else begin
          ifu_slot_d       = SLOT_HELD;
          ifu_hold_rdata_d = ifu_live_rdata;
          ifu_hold_err_d   = ifu_live_err_q;
        end
      end
      SLOT_HELD: if (ifu_fire) ifu_slot_d = SLOT_EMPTY;
      default: ;
    endcase
    if (ifu_acc) begin
      ifu_slot_d      = SLOT_LIVE;
      ifu_live_zero_d = ifu_err;
      ifu_live_err_d  = ifu_err;
    end
    // Flush wins over the LIVE->HELD capture so the fetch is dropped outright.
    if (bus.flush) ifu_slot_d = SLOT_EMPTY;

    lsu_slot_d       = lsu_slot_q;
    lsu_hold_rdata_d = lsu_hold_rdata_q;
    lsu_hold_err_d   = lsu_hold_err_q;
    lsu_live_zero_d  = lsu_live_zero_q;
    lsu_live_err_d   = lsu_live_err_q;
    case (lsu_slot_q)
      SLOT_LIVE: begin
        if (lsu_fire) begin
          lsu_slot_d = SLOT_EMPTY;
        end else begin
          lsu_slot_d       = SLOT_HELD;
          lsu_hold_rdata_d = lsu_live_rdata;
          lsu_hold_err_d   = lsu_live_err_q;
        end
      end
      SLOT_HELD: if (lsu_fire) lsu_slot_d = SLOT_EMPTY;
      default: ;
    endcase
    if (lsu_acc) begin
      lsu_slot_d      = SLOT_LIVE;
      lsu_live_zero_d = lsu_err || !bus.lsu_cmd_read;
      lsu_live_err_d  = lsu_err;
    end
  end

  // State registers, cleared asynchronously so in-flight accesses are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_slot_q       <= SLOT_EMPTY;
      lsu_slot_q       <= SLOT_EMPTY;
      starve_q         <= '0;
      ifu_hold_rdata_q <= '0;
      ifu_hold_err_q   <= 1'b0;
      lsu_hold_rdata_q <= '0;
      lsu_hold_err_q   <= 1'b0;
      ifu_live_zero_q  <= 1'b0;
      ifu_live_err_q   <= 1'b0;
      lsu_live_zero_q  <= 1'b0;
      lsu_live_err_q   <= 1'b0;
    end else begin
      ifu_slot_q       <= ifu_slot_d;
      lsu_slot_q       <= lsu_slot_d;
      starve_q         <= starve_d;
      ifu_hold_rdata_q <= ifu_hold_rdata_d;
      ifu_hold_err_q   <= ifu_hold_err_d;
      lsu_hold_rdata_q <= lsu_hold_rdata_d;
      lsu_hold_err_q   <= lsu_hold_err_d;
      ifu_live_zero_q  <= ifu_live_zero_d;
      ifu_live_err_q   <= ifu_live_err_d;
      lsu_live_zero_q  <= lsu_live_zero_d;
      lsu_live_err_q   <= lsu_live_err_d;
    end
  end

endmodule

// File: tb/tb_itcm_arbiter.sv
// Bench for itcm_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model
// (per-port response queues, a starvation count and a shadow memory).
module tb_itcm_arbiter;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itcm_arbiter_if #(.AW(32), .DW(32), .RAM_DEPTH(14)) bus();

  itcm_arbiter #(
    .AW(32), .DW(32), .RAM_DEPTH(14), .REGION_BASE(32'h0), .STARVE_MAX(SM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] initw(input int unsigned i);
    return 32'hC0DE_0000 | (32'(i) * 32'h0000_0101);
  endfunction

  // RAM environment: data one cycle after ena, garbage on idle cycles
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= initw(i);
      bus.ram_dout <= $urandom;
    end else if (bus.ram_ena) begin
      bus.ram_dout <= mem[bus.ram_addr[5:0]];
      for (int b = 0; b < 4; b++)
        if (bus.ram_wea[b]) mem[bus.ram_addr[5:0]][8*b +: 8] <= bus.ram_din[8*b +: 8];
    end else begin
      bus.ram_dout <= $urandom;
    end
  end

  typedef struct { logic err; logic [31:0] data; } rsp_t;
  rsp_t        ifu_q[$];
  rsp_t        lsu_q[$];
  int          starve;
  logic [31:0] ref_mem [64];

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:16] != 16'h0);
  endfunction

  // Cycle-level comparison at the negedge, then advance the reference model
  task automatic model_check();
    logic grant_ifu, ifu_fire, lsu_fire, exp_ifu_rdy, exp_lsu_rdy;
    logic ifu_acc, lsu_acc, ie, le, exp_ena;
    logic [31:0] exp_wea, exp_addr, w;
    rsp_t r;
    if (rst) begin
      chk("rst_ifu_cmd_ready", 32'(bus.ifu_cmd_ready), 0);
      chk("rst_lsu_cmd_ready", 32'(bus.lsu_cmd_ready), 0);
      chk("rst_ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 0);
      chk("rst_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 0);
      chk("rst_ram_ena",       32'(bus.ram_ena), 0);
      chk("rst_ram_wea",       32'(bus.ram_wea), 0);
      chk("rst_rdata_err",     {bus.ifu_rsp_rdata | bus.lsu_rsp_rdata}, 0);
      chk("rst_err",           32'({bus.ifu_rsp_err, bus.lsu_rsp_err}), 0);
      ifu_q.delete();
      lsu_q.delete();
      starve = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = initw(i);
      return;
    end
    grant_ifu   = !bus.lsu_cmd_valid || (starve == SM);
    ifu_fire    = (ifu_q.size() > 0) && !bus.flush && bus.ifu_rsp_ready;
    lsu_fire    = (lsu_q.size() > 0) && bus.lsu_rsp_ready;
    exp_ifu_rdy = !bus.flush && grant_ifu && ((ifu_q.size() == 0) || ifu_fire);
    exp_lsu_rdy = !grant_ifu && ((lsu_q.size() == 0) || lsu_fire);
    chk("ifu_cmd_ready", 32'(bus.ifu_cmd_ready), 32'(exp_ifu_rdy));
    chk("lsu_cmd_ready", 32'(bus.lsu_cmd_ready), 32'(exp_lsu_rdy));
    chk("ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'((ifu_q.size() > 0) && !bus.flush));
    chk("lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'(lsu_q.size() > 0));
    if (ifu_q.size() > 0 && !bus.flush) begin
      chk("ifu_rsp_rdata", bus.ifu_rsp_rdata, ifu_q[0].data);
      chk("ifu_rsp_err",   32'(bus.ifu_rsp_err), 32'(ifu_q[0].err));
    end
    if (lsu_q.size() > 0) begin
      chk("lsu_rsp_rdata", bus.lsu_rsp_rdata, lsu_q[0].data);
      chk("lsu_rsp_err",   32'(bus.lsu_rsp_err), 32'(lsu_q[0].err));
    end
    ifu_acc = bus.ifu_cmd_valid && exp_ifu_rdy;
    lsu_acc = bus.lsu_cmd_valid && exp_lsu_rdy;
    ie = bad_addr(bus.ifu_cmd_addr);
    le = bad_addr(bus.lsu_cmd_addr);
    exp_ena = (ifu_acc && !ie) || (lsu_acc && !le);
    exp_wea = (lsu_acc && !le && !bus.lsu_cmd_read) ? 32'(bus.lsu_cmd_wmask) : 0;
    chk("ram_ena", 32'(bus.ram_ena), 32'(exp_ena));
    chk("ram_wea", 32'(bus.ram_wea), exp_wea);
    if (exp_ena) begin
      exp_addr = ifu_acc ? {18'h0, bus.ifu_cmd_addr[15:2]} : {18'h0, bus.lsu_cmd_addr[15:2]};
      chk("ram_addr", 32'(bus.ram_addr), exp_addr);
      if (lsu_acc && !bus.lsu_cmd_read) chk("ram_din", bus.ram_din, bus.lsu_cmd_wdata);
    end
    if (ifu_fire) void'(ifu_q.pop_front());
    if (lsu_fire) void'(lsu_q.pop_front());
    if (bus.flush) ifu_q.delete();
    if (ifu_acc) begin
      r.err  = ie;
      r.data = ie ? 32'h0 : ref_mem[bus.ifu_cmd_addr[7:2]];
      ifu_q.push_back(r);
    end
    if (lsu_acc) begin
      r.err = le;
      if (le || !bus.lsu_cmd_read) r.data = 32'h0;
      else                         r.data = ref_mem[bus.lsu_cmd_addr[7:2]];
      lsu_q.push_back(r);
      if (!le && !bus.lsu_cmd_read) begin
        w = ref_mem[bus.lsu_cmd_addr[7:2]];
        for (int b = 0; b < 4; b++)
          if (bus.lsu_cmd_wmask[b]) w[8*b +: 8] = bus.lsu_cmd_wdata[8*b +: 8];
        ref_mem[bus.lsu_cmd_addr[7:2]] = w;
      end
    end
    if (!bus.ifu_cmd_valid || ifu_acc) starve = 0;
    else if (starve < SM)              starve = starve + 1;
  endtask

  task automatic sample(); @(negedge clk); model_check(); endtask
  task automatic adv();    @(posedge clk); #1;            endtask

  task automatic idle(input int n);
    bus.ifu_cmd_valid = 0; bus.lsu_cmd_valid = 0; bus.flush = 0;
    bus.ifu_rsp_ready = 1; bus.lsu_rsp_ready = 1;
    for (int i = 0; i < n; i++) begin sample(); adv(); end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    int unsigned k;
    a = 32'($urandom_range(0, 63)) << 2;
    k = $urandom_range(0, 7);
    if (k == 0) a = a | 32'($urandom_range(1, 3));
    else if (k == 1) a = a | (32'h0001_0000 << $urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    int ifu_cycle, lsu_cnt;
    logic lsu_rdy5;
    rst = 1;
    bus.ifu_cmd_valid = 0; bus.ifu_cmd_addr = 0; bus.ifu_rsp_ready = 0; bus.flush = 0;
    bus.lsu_cmd_valid = 0; bus.lsu_cmd_read = 1; bus.lsu_cmd_addr = 0;
    bus.lsu_cmd_wdata = 0; bus.lsu_cmd_wmask = 0; bus.lsu_rsp_ready = 0;
    sample(); adv();
    rst = 0;
    idle(2);

    // IFU alone reads 0x10
    bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = 32'h10;
    sample();
    chk("ifu_alone_ena", 32'(bus.ram_ena), 1);
    chk("ifu_alone_addr", 32'(bus.ram_addr), 4);
    adv();
    bus.ifu_cmd_valid = 0;
    sample();
    chk("ifu_alone_valid", 32'(bus.ifu_rsp_valid), 1);
    chk("ifu_alone_rdata", bus.ifu_rsp_rdata, initw(4));
    chk("ifu_alone_err", 32'(bus.ifu_rsp_err), 0);
    adv();
    idle(1);

    // Both ports valid continuously: IFU forced through on the fifth cycle
    bus.lsu_cmd_valid = 1; bus.lsu_cmd_read = 1; bus.lsu_cmd_addr = 32'h0;
    bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = 32'h4;
    ifu_cycle = -1; lsu_cnt = 0; lsu_rdy5 = 0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (bus.ifu_cmd_ready && ifu_cycle < 0) ifu_cycle = c;
      if (bus.lsu_cmd_ready && ifu_cycle < 0) lsu_cnt++;
      if (c == 5) lsu_rdy5 = bus.lsu_cmd_ready;
      adv();
    end
    chk("starve_ifu_cycle", 32'(ifu_cycle), 4);
    chk("starve_lsu_cnt", 32'(lsu_cnt), 4);
    chk("starve_cleared", 32'(lsu_rdy5), 1);
    idle(2);

    // LSU read 0x20 stalled three cycles while the IFU keeps the RAM busy
    bus.lsu_cmd_valid = 1; bus.lsu_cmd_read = 1; bus.lsu_cmd_addr = 32'h20;
    bus.lsu_rsp_ready = 0;
    sample(); adv();
    bus.lsu_cmd_valid = 0;
    bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = 32'h40;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("lsu_stall_valid", 32'(bus.lsu_rsp_valid), 1);
      chk("lsu_stall_rdata", bus.lsu_rsp_rdata, initw(8));
      adv();
    end
    bus.ifu_cmd_valid = 0; bus.lsu_rsp_ready = 1;
    sample();
    chk("lsu_release_rdata", bus.lsu_rsp_rdata, initw(8));
    adv();
    sample();
    chk("lsu_after_fire", 32'(bus.lsu_rsp_valid), 0);
    adv();
    idle(1);

    // Erroneous IFU addresses
    bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = 32'h2;
    sample();
    chk("err_misalign_ena", 32'(bus.ram_ena), 0);
    adv();
    bus.ifu_cmd_addr = 32'h8000_0000;
    sample();
    chk("err_region_ena", 32'(bus.ram_ena), 0);
    chk("err_misalign_rsp", {bus.ifu_rsp_rdata[30:0], bus.ifu_rsp_err}, 1);
    adv();
    bus.ifu_cmd_valid = 0;
    sample();
    chk("err_region_rsp", {bus.ifu_rsp_rdata[30:0], bus.ifu_rsp_err}, 1);
    adv();
    idle(1);

    // LSU partial write
    bus.lsu_cmd_valid = 1; bus.lsu_cmd_read = 0; bus.lsu_cmd_addr = 32'h8;
    bus.lsu_cmd_wdata = 32'hDEAD_BEEF; bus.lsu_cmd_wmask = 4'b0011;
    sample();
    chk("wr_wea", 32'(bus.ram_wea), 32'h3);
    chk("wr_addr", 32'(bus.ram_addr), 2);
    adv();
    bus.lsu_cmd_valid = 0;
    sample();
    chk("wr_rsp", {bus.lsu_rsp_rdata[30:0], bus.lsu_rsp_err}, 0);
    adv();
    idle(1);

    // IFU response held, then flushed
    bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = 32'h0; bus.ifu_rsp_ready = 0;
    sample(); adv();
    bus.ifu_cmd_valid = 0;
    sample(); adv();
    sample(); adv();
    bus.flush = 1;
    sample();
    chk("flush_rsp_valid", 32'(bus.ifu_rsp_valid), 0);
    adv();
    bus.flush = 0; bus.ifu_rsp_ready = 1;
    sample();
    chk("post_flush_valid", 32'(bus.ifu_rsp_valid), 0);
    adv();
    idle(1);

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      bus.ifu_cmd_valid = ($urandom_range(0, 9) < 7);
      bus.ifu_cmd_addr  = rnd_addr();
      bus.lsu_cmd_valid = ($urandom_range(0, 9) < 6);
      bus.lsu_cmd_read  = $urandom_range(0, 1) == 1;
      bus.lsu_cmd_addr  = rnd_addr();
      bus.lsu_cmd_wdata = $urandom;
      bus.lsu_cmd_wmask = 4'($urandom_range(0, 15));
      bus.ifu_rsp_ready = ($urandom_range(0, 9) < 7);
      bus.lsu_rsp_ready = ($urandom_range(0, 9) < 7);
      bus.flush         = ($urandom_range(0, 19) == 0);
      sample(); adv();
    end
    idle(2);

    // Reset while a response is LIVE
    bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = 32'hC;
    sample(); adv();
    bus.ifu_cmd_valid = 0;
    rst = 1;
    sample();
    chk("rst_live_valid", 32'(bus.ifu_rsp_valid), 0);
    adv();
    rst = 0;
    sample();
    chk("post_rst_no_rsp", 32'(bus.ifu_rsp_valid), 0);
    adv();
    bus.ifu_cmd_valid = 1; bus.ifu_cmd_addr = 32'h4;
    sample();
    chk("post_rst_accept", 32'(bus.ifu_cmd_ready), 1);
    adv();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
